// File: rtl/perf_pkg.sv
// Shared constants and types for the performance-counter unit.
package perf_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int Q_FRAC    = 8;

  localparam logic [4:0] PERF_REG_STALL = 5'd24;
  localparam logic [4:0] PERF_REG_CPI   = 5'd25;
  localparam logic [4:0] PERF_REG_ARITH = 5'd26;
  localparam logic [4:0] PERF_REG_MEM   = 5'd27;

  localparam logic [15:0] CPI_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    CPI_IDLE,
    CPI_DIV,
    CPI_DONE
  } cpi_state_t;

endpackage

// File: rtl/perf_cpi_div.sv
// Restoring divider, one quotient bit per cycle, CNT_W+Q_FRAC cycles per divide.
module perf_cpi_div
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      abort,
  input  logic                      start,
  input  logic [CNT_W+Q_FRAC-1:0]   dividend,
  input  logic [CNT_W-1:0]          divisor,
  output logic [CNT_W+Q_FRAC-1:0]   quotient,
  output logic                      done
);

  localparam int QW = CNT_W + Q_FRAC;
  localparam int BW = $clog2(QW + 1);

  logic [QW-1:0]    dvd;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dsr;
  logic [BW-1:0]    bits_left;
  logic             busy;

  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] diff;
  logic             fits;

  // Remainder stays below the divisor, so the low CNT_W bits of the difference are exact.
  always_comb begin
    rem_sh = {rem, dvd[QW-1]};
    fits   = (rem_sh >= {1'b0, dsr});
    diff   = rem_sh[CNT_W-1:0] - dsr;
  end

  always_ff @(posedge clk) begin
    if (abort) begin
      busy      <= 1'b0;
      bits_left <= '0;
    end else if (start) begin
      dvd       <= dividend;
      rem       <= '0;
      dsr       <= divisor;
      bits_left <= BW'(QW);
      busy      <= 1'b1;
    end else if (busy) begin
      rem       <= fits ? diff : rem_sh[CNT_W-1:0];
      dvd       <= {dvd[QW-2:0], fits};
      bits_left <= bits_left - BW'(1);
      busy      <= (bits_left != BW'(1));
    end
  end

  // The quotient shifts into dvd in place; it is complete after the edge where done is high.
  assign done     = busy & (bits_left == BW'(1));
  assign quotient = dvd;

endmodule

// File: rtl/perf_counters_vec.sv
// Performance counters (stall/arith/mem) and Q7.8 CPI for vector counter registers 24..27.
// PERF_SATURATE_EN: counters hold at all-ones instead of wrapping.
//
//   state    | meaning
//   CPI_IDLE | waiting for a non-zero retire count, snapshot on exit
//   CPI_DIV  | divider computing cycle_cnt*256 / ret_cnt
//   CPI_DONE | latch saturated quotient into cpi_q78
module perf_counters_vec
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         retire,
  input  logic         is_arith,
  input  logic         is_mem,
  input  logic         perf_clear,
  output logic [255:0] stall_count_out,
  output logic [255:0] cycles_per_instruction_q78_out,
  output logic [255:0] arith_count_out,
  output logic [255:0] mem_access_count_out
);

  localparam int QW = CNT_W + Q_FRAC;

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] arith_cnt;
  logic [CNT_W-1:0] mem_cnt;
  logic [15:0]      cpi_q78;
  logic [15:0]      cpi_sat;

  cpi_state_t       state;
  cpi_state_t       state_nxt;
  logic             div_start;
  logic             div_done;
  logic [QW-1:0]    quotient;
  logic             clr;

  assign clr = rst | perf_clear;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
    return (&v) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      ret_cnt   <= '0;
      arith_cnt <= '0;
      mem_cnt   <= '0;
    end else begin
      cycle_cnt <= bump(cycle_cnt);
      if (stall)             stall_cnt <= bump(stall_cnt);
      if (retire)            ret_cnt   <= bump(ret_cnt);
      if (retire & is_arith) arith_cnt <= bump(arith_cnt);
      if (retire & is_mem)   mem_cnt   <= bump(mem_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state <= CPI_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      CPI_IDLE: begin
        if (ret_cnt != '0) begin
          div_start = 1'b1;
          state_nxt = CPI_DIV;
        end
      end
      CPI_DIV:  if (div_done) state_nxt = CPI_DONE;
      CPI_DONE: state_nxt = CPI_IDLE;
      default:  state_nxt = CPI_IDLE;
    endcase
  end

  perf_cpi_div #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .abort    (clr),
    .start    (div_start),
    .dividend ({cycle_cnt, {Q_FRAC{1'b0}}}),
    .divisor  (ret_cnt),
    .quotient (quotient),
    .done     (div_done)
  );

  // Integer part wider than 8 bits cannot be represented in Q7.8.
  generate
    if (QW > 16) begin : g_sat
      always_comb cpi_sat = (|quotient[QW-1:16]) ? CPI_MAX : quotient[15:0];
    end else begin : g_nosat
      always_comb cpi_sat = quotient[15:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr)                    cpi_q78 <= '0;
    else if (state == CPI_DONE) cpi_q78 <= cpi_sat;
  end

  assign stall_count_out                = {{(256-CNT_W){1'b0}}, stall_cnt};
  assign arith_count_out                = {{(256-CNT_W){1'b0}}, arith_cnt};
  assign mem_access_count_out           = {{(256-CNT_W){1'b0}}, mem_cnt};
  assign cycles_per_instruction_q78_out = {240'b0, cpi_q78};

endmodule

// File: tb/tb_perf_counters_vec.sv
// Directed bench: counter vector table plus CPI timing, abort and saturation sequences.
module tb_perf_counters_vec;
  import perf_pkg::*;

  logic         clk;
  logic         rst;
  logic         stall, retire, is_arith, is_mem, perf_clear;
  logic [255:0] stall_o, cpi_o, arith_o, mem_o;

  logic         clear8, stall8, zero8;
  logic [255:0] stall8_o, cpi8_o, arith8_o, mem8_o;

  int checks = 0;
  int errors = 0;

  perf_counters_vec #(.CNT_W(32)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .stall                          (stall),
    .retire                         (retire),
    .is_arith                       (is_arith),
    .is_mem                         (is_mem),
    .perf_clear                     (perf_clear),
    .stall_count_out                (stall_o),
    .cycles_per_instruction_q78_out (cpi_o),
    .arith_count_out                (arith_o),
    .mem_access_count_out           (mem_o)
  );

  perf_counters_vec #(.CNT_W(8)) dut8 (
    .clk                            (clk),
    .rst                            (rst),
    .stall                          (stall8),
    .retire                         (zero8),
    .is_arith                       (zero8),
    .is_mem                         (zero8),
    .perf_clear                     (clear8),
    .stall_count_out                (stall8_o),
    .cycles_per_instruction_q78_out (cpi8_o),
    .arith_count_out                (arith8_o),
    .mem_access_count_out           (mem8_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, re, ar, me, cl;
    int unsigned e_stall, e_arith, e_mem;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic st, logic re, logic ar, logic me, logic cl,
                              int unsigned es, int unsigned ea, int unsigned em);
    vec_t v;
    v.st = st; v.re = re; v.ar = ar; v.me = me; v.cl = cl;
    v.e_stall = es; v.e_arith = ea; v.e_mem = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic st, input logic re, input logic ar, input logic me, input logic cl);
    stall = st; retire = re; is_arith = ar; is_mem = me; perf_clear = cl;
  endtask

  task automatic pulse_clear;
    set_ev(0, 0, 0, 0, 1);
    tick;
    set_ev(0, 0, 0, 0, 0);
  endtask

  int idle_cycles;

  initial begin
    // Reset held for two cycles with every event asserted.
    rst = 1'b1; zero8 = 1'b0; clear8 = 1'b0; stall8 = 1'b1;
    set_ev(1, 1, 1, 1, 0);
    tick;
    tick;
    chk("rst stall", stall_o, '0);
    chk("rst cpi",   cpi_o,   '0);
    chk("rst arith", arith_o, '0);
    chk("rst mem",   mem_o,   '0);
    chk("rst state", 256'(dut.state), 256'(CPI_IDLE));
    chk("rst stall8", stall8_o, '0);
    rst = 1'b0; stall8 = 1'b0;
    set_ev(0, 0, 0, 0, 0);

    // Counter table: clear-wins rows, arith/mem qualification by retire, dual-class retires.
    vecs[0]  = mk(1, 1, 1, 1, 1, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 0, 0, 1, 1, 0);
    vecs[2]  = mk(1, 1, 1, 1, 0, 2, 2, 1);
    vecs[3]  = mk(1, 0, 1, 1, 0, 3, 2, 1);
    vecs[4]  = mk(1, 1, 1, 0, 0, 4, 3, 1);
    vecs[5]  = mk(0, 1, 1, 1, 0, 4, 4, 2);
    vecs[6]  = mk(1, 1, 1, 0, 0, 5, 5, 2);
    vecs[7]  = mk(1, 0, 0, 0, 0, 6, 5, 2);
    vecs[8]  = mk(1, 0, 0, 0, 0, 7, 5, 2);
    vecs[9]  = mk(0, 1, 0, 0, 0, 7, 5, 2);
    vecs[10] = mk(1, 1, 1, 1, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      set_ev(vecs[i].st, vecs[i].re, vecs[i].ar, vecs[i].me, vecs[i].cl);
      tick;
      chk($sformatf("vec%0d stall", i), stall_o, 256'(vecs[i].e_stall));
      chk($sformatf("vec%0d arith", i), arith_o, 256'(vecs[i].e_arith));
      chk($sformatf("vec%0d mem", i),   mem_o,   256'(vecs[i].e_mem));
    end

    // Retire every 4th cycle: snapshots at cycles 4/1, 46/11, 88/22.
    pulse_clear;
    for (int k = 1; k <= 140; k++) begin
      set_ev(0, (k % 4 == 0), 1, 0, 0);
      tick;
      if (k == 45)  chk("cpi4 before first done", cpi_o, 256'(16'h0000));
      if (k == 46)  chk("cpi4 first",  cpi_o, 256'(16'h0400));
      if (k == 88)  chk("cpi4 second", cpi_o, 256'(16'h042E));
      if (k == 130) chk("cpi4 third",  cpi_o, 256'(16'h0400));
    end
    // Division of snapshot 130/32 is in flight; clear it together with live events.
    chk("mid state div", 256'(dut.state), 256'(CPI_DIV));
    set_ev(1, 1, 1, 1, 1);
    tick;
    chk("abort stall", stall_o, '0);
    chk("abort cpi",   cpi_o,   '0);
    chk("abort arith", arith_o, '0);
    chk("abort mem",   mem_o,   '0);
    chk("abort state", 256'(dut.state), 256'(CPI_IDLE));
    for (int k = 1; k <= 86; k++) begin
      set_ev(0, (k % 2 == 0), 0, 0, 0);
      tick;
      if (k == 43) chk("post-clear cpi idle", cpi_o, 256'(16'h0000));
      if (k == 44) chk("post-clear cpi first", cpi_o, 256'(16'h0200));
      if (k == 86) chk("post-clear cpi second", cpi_o, 256'(16'h0200));
    end

    // Retire when k%3==1: snapshots 1/1, 43/15, 85/29 with truncated fractions.
    pulse_clear;
    for (int k = 1; k <= 127; k++) begin
      set_ev(0, (k % 3 == 1), 0, 0, 0);
      tick;
      if (k == 43)  chk("cpi3 first",  cpi_o, 256'(16'h0100));
      if (k == 85)  chk("cpi3 second", cpi_o, 256'(16'h02DD));
      if (k == 127) chk("cpi3 third",  cpi_o, 256'(16'h02EE));
    end

    // Long idle, then a single retire: 300*256 saturates.
    pulse_clear;
    idle_cycles = 0;
    for (int k = 1; k <= 500; k++) begin
      set_ev(0, (k == 300), 0, 0, 0);
      tick;
      if (k <= 300 && dut.state == CPI_IDLE) idle_cycles++;
      if (k == 299) chk("no-retire cpi", cpi_o, 256'(16'h0000));
      if (k == 300) chk("idle cycles", 256'(idle_cycles), 256'(300));
      if (k == 341) chk("sat cpi before done", cpi_o, 256'(16'h0000));
      if (k == 342) chk("sat cpi", cpi_o, 256'(16'hFFFF));
    end
    set_ev(0, 0, 0, 0, 0);

    // CNT_W=8 stall counter at the wrap boundary.
    clear8 = 1'b1;
    tick;
    clear8 = 1'b0;
    stall8 = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      tick;
      if (k == 255) chk("w8 stall 255", stall8_o, 256'(255));
    end
    stall8 = 1'b0;
`ifdef PERF_SATURATE_EN
    chk("w8 stall 256", stall8_o, 256'(255));
`else
    chk("w8 stall 256", stall8_o, 256'(0));
`endif
    chk("w8 cpi", cpi8_o, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
